mc14500_sequencer: RTL and testbench
====================================

Name: mc14500_sequencer

Overview:
- Program sequencer for the MC14500 ICU core in the user project area.
- Owns the program counter and a return-address stack, and fetches 8-bit instruction bytes (opcode[7:4], operand[3:0]) from program memory over a req/ack handshake.
- Issues each instruction to the ICU core and interprets the core's control-flow opcodes: JMP as call with push, RTN as pop plus skip, SKZ as conditional skip.
- Management SoC starts/stops it and may preload the PC while it is idle.

Parameters:
- ADDR_W, 8: program address width; legal range 4..8. JMP target byte is truncated to ADDR_W.
- STACK_DEPTH, 4: return-stack entries; legal range 1..8.
- RESET_VEC, 0: PC value after reset.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  run enable.
- pc_load  in  1  PC load strobe; honoured only in IDLE.
- pc_load_val  in  ADDR_W  value for PC load.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address.
- mem_ack  in  1  fetch done; mem_rdata valid in the same cycle.
- mem_rdata  in  8  fetched byte.
- issue_valid  out  1  instruction presented to the core.
- issue_op  out  4  opcode.
- issue_opr  out  4  operand (I/O address).
- core_ready  in  1  core accepts the instruction.
- core_rr  in  1  core result register, sampled on SKZ accept.
- pc  out  ADDR_W  current PC.
- sp  out  4  stack depth.
- busy  out  1  state != IDLE.
- stack_ovf  out  1  sticky overflow flag.
- stack_unf  out  1  sticky underflow flag.

Behaviour:
- Opcodes: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF. All opcodes, including C/D/E, are issued to the core.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=RESET_VEC, sp=0, skip_pending=0.
  - stack_ovf=stack_unf=0, mem_req=0, issue_valid=0, issue_op=issue_opr=0.
  - Reset mid-handshake abandons the handshake immediately.
- IDLE:
  - pc_load=1: pc<=pc_load_val, sp<=0, flags cleared.
  - en=1 (same cycle as pc_load allowed; the load wins the pc value): go to FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc, held stable until mem_ack. Ack in the same cycle as req is legal.
  - On ack: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W, wraps).
  - If skip_pending: clear it and discard the byte. If the discarded opcode is C, go to SKIP_TGT; otherwise go to FETCH if en, else IDLE.
  - Else: opcode C goes to FETCH_TGT; all others go to ISSUE.
- SKIP_TGT: fetch the handshake at pc, discard the data, pc<=pc+1, then FETCH/IDLE per en.
- FETCH_TGT: fetch at pc; on ack tgt<=mem_rdata[ADDR_W-1:0], pc<=pc+1, go to ISSUE.
- ISSUE:
  - issue_valid=1 with op/opr held until core_ready. Registered outputs; issue_valid drops the cycle after accept.
  - On accept, by opcode:
    - C: if sp<STACK_DEPTH, push pc (address after the target byte) and sp++; else set stack_ovf, no push. pc<=tgt in both cases.
    - D: if sp>0, pc<=top and sp--; else set stack_unf, pc unchanged. skip_pending<=1 in both cases.
    - E: skip_pending<=~core_rr.
  - Then go to FETCH if en, else IDLE.
- Latency with zero-wait ack and ready: 2 cycles per instruction, 3 per JMP.
- en deassert mid-instruction: the current instruction completes; return to IDLE with pc and stack preserved. skip_pending is also preserved and applies on restart.
- pc wraps from 2^ADDR_W-1 to 0 in every increment path.

Test Plan:
- Reset then en=1, memory {0x11,0x83,0x00} with zero-wait ack/ready → issue (1,1),(8,3),(0,0) on cycles 2,4,6 after en; pc=3.
- JMP call/return: mem[0]=0xC0, mem[1]=0x10, mem[2]=0x22, mem[3]=0x33, mem[0x10]=0xD0 → issue order C,D,3 (mem[2] skipped); sp goes 1→0; issued opr of C is 0.
- SKZ: mem {0xE0,0xC0,0x20,0x15} with core_rr=0 → JMP and its target byte skipped, next issue is (1,5), pc=4; with core_rr=1 → JMP issued, pc=0x20.
- STACK_DEPTH=2: three nested JMPs → sp=2, stack_ovf=1, third jump still taken; RTN at sp=0 → stack_unf=1, pc unchanged, next byte skipped.
- Handshake stalls: mem_ack delayed 3 cycles, core_ready delayed 2 → mem_addr and issue_op stable throughout, one issue per instruction, no duplicate fetches.
- en drop during ISSUE then pc_load=0x40 in IDLE → current instruction completes, busy=0, pc=0x40, sp=0; re-enable fetches from 0x40. Reset asserted mid-FETCH → mem_req=0 next cycle, pc=RESET_VEC.

Source files
------------

// File: rtl/mc14500_sequencer.sv
// mc14500_sequencer: program counter, return stack and fetch/issue control for the MC14500 ICU core
module mc14500_sequencer #(
    parameter int ADDR_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              issue_valid,
    output logic [3:0]        issue_op,
    output logic [3:0]        issue_opr,
    input  logic              core_ready,
    input  logic              core_rr,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        sp,
    output logic              busy,
    output logic              stack_ovf,
    output logic              stack_unf
);
    localparam int SW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, SKIP_TGT, FETCH_TGT, ISSUE} state_t;
    state_t state, state_nx;
    logic [7:0] ir;
    logic [ADDR_W-1:0] tgt, pc_inc;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic skip_pending, accept, push;
    logic [SW-1:0] top;
    assign pc_inc = pc + ADDR_W'(1);
    assign accept = state == ISSUE && core_ready;
    assign push = accept && ir[7:4] == 4'hC && sp < 4'(STACK_DEPTH);
    assign top = SW'(sp - 4'd1);
    assign mem_req = state == FETCH || state == SKIP_TGT || state == FETCH_TGT;
    assign mem_addr = pc;
    assign issue_valid = state == ISSUE;
    assign issue_op = ir[7:4];
    assign issue_opr = ir[3:0];
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = en ? FETCH : IDLE;
            FETCH:     if (mem_ack) state_nx = skip_pending ? (mem_rdata[7:4] == 4'hC ? SKIP_TGT : (en ? FETCH : IDLE))
                                                            : (mem_rdata[7:4] == 4'hC ? FETCH_TGT : ISSUE);
            SKIP_TGT:  if (mem_ack) state_nx = en ? FETCH : IDLE;
            FETCH_TGT: if (mem_ack) state_nx = ISSUE;
            ISSUE:     if (core_ready) state_nx = en ? FETCH : IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) stack[sp[SW-1:0]] <= pc;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_VEC;
            sp <= '0;
            skip_pending <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            ir <= '0;
            tgt <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (pc_load) begin
                    pc <= pc_load_val;
                    sp <= '0;
                    stack_ovf <= 1'b0;
                    stack_unf <= 1'b0;
                end
                FETCH: if (mem_ack) begin
                    ir <= mem_rdata;
                    pc <= pc_inc;
                    skip_pending <= 1'b0;
                end
                SKIP_TGT: if (mem_ack) pc <= pc_inc;
                FETCH_TGT: if (mem_ack) begin
                    tgt <= mem_rdata[ADDR_W-1:0];
                    pc <= pc_inc;
                end
                ISSUE: if (core_ready) begin
                    unique case (ir[7:4])
                        4'hC: begin
                            pc <= tgt;
                            if (push) sp <= sp + 4'd1;
                            else stack_ovf <= 1'b1;
                        end
                        4'hD: begin
                            skip_pending <= 1'b1;
                            if (sp != 4'd0) begin
                                pc <= stack[top];
                                sp <= sp - 4'd1;
                            end else stack_unf <= 1'b1;
                        end
                        4'hE: skip_pending <= ~core_rr;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc14500_sequencer.sv
// tb_mc14500_sequencer: scoreboard bench driving random memory/core handshakes against an instruction-level model
module tb_mc14500_sequencer;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst_n, en, pc_load, mem_ack, core_ready, core_rr;
    logic [7:0] pc_load_val, mem_rdata;
    logic mem_req, issue_valid, busy, stack_ovf, stack_unf;
    logic [7:0] mem_addr, pc;
    logic [3:0] issue_op, issue_opr, sp;
    logic [7:0] mem [256];
    logic rr_seq [256];
    logic [7:0] exp_q[$];
    logic [7:0] acc_ops[$];
    int acc_cyc[$];
    int checks = 0, fails = 0;
    int cyc = 0, c0 = 0, acc_cnt = 0, fetch_cnt = 0, stop_at = -1;
    int ack_pct = 100, rdy_pct = 100;
    int m_pc, m_sp, m_fetch;
    bit m_ovf, m_unf;
    bit prev_mwait = 0, prev_iwait = 0;
    logic [7:0] prev_addr, prev_ins;

    mc14500_sequencer #(.ADDR_W(8), .STACK_DEPTH(DEPTH), .RESET_VEC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_opr(issue_opr),
        .core_ready(core_ready), .core_rr(core_rr), .pc(pc), .sp(sp), .busy(busy),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf));

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Instruction-level reference: walks the program byte by byte as the ISA defines it
    task automatic model_run(input int start, input int n);
        int p = start;
        int stk[$];
        bit skip = 0;
        int k = 0;
        m_ovf = 0; m_unf = 0; m_fetch = 0;
        while (k < n) begin
            logic [7:0] b;
            b = mem[p]; p = (p + 1) % 256; m_fetch++;
            if (skip) begin
                skip = 0;
                if (b[7:4] == 4'hC) begin p = (p + 1) % 256; m_fetch++; end
            end else begin
                exp_q.push_back(b);
                if (b[7:4] == 4'hC) begin
                    int t;
                    t = int'(mem[p]); p = (p + 1) % 256; m_fetch++;
                    if (stk.size() < DEPTH) stk.push_back(p); else m_ovf = 1;
                    p = t;
                end else if (b[7:4] == 4'hD) begin
                    if (stk.size() > 0) p = stk.pop_back(); else m_unf = 1;
                    skip = 1;
                end else if (b[7:4] == 4'hE) skip = !rr_seq[k];
                k++;
            end
        end
        m_pc = p; m_sp = stk.size();
    endtask

    // Memory and core responders
    initial forever begin
        @(negedge clk);
        mem_ack = mem_req && ($urandom_range(99) < ack_pct);
        mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
        core_ready = issue_valid && ($urandom_range(99) < rdy_pct);
        core_rr = rr_seq[acc_cnt % 256];
        if (issue_valid && core_ready && acc_cnt == stop_at - 1) en = 1'b0;
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_mwait = 0; prev_iwait = 0;
        end else begin
            if (prev_mwait) check("mem_addr_stable", mem_addr, prev_addr);
            if (prev_iwait) check("issue_stable", {issue_op, issue_opr}, prev_ins);
            prev_mwait = mem_req && !mem_ack; prev_addr = mem_addr;
            prev_iwait = issue_valid && !core_ready; prev_ins = {issue_op, issue_opr};
            if (mem_req && mem_ack) fetch_cnt++;
            if (issue_valid && core_ready) begin
                if (exp_q.size() == 0) check("issue_unexpected", {issue_op, issue_opr}, -1);
                else check("issue", {issue_op, issue_opr}, exp_q.pop_front());
                acc_ops.push_back({issue_op, issue_opr});
                acc_cyc.push_back(cyc);
                acc_cnt++;
            end
        end
    end

    task automatic run(input int start, input int n, input int ap, input int rp);
        bit done = 0;
        @(negedge clk);
        rst_n = 0; en = 0; pc_load = 0; ack_pct = ap; rdy_pct = rp;
        repeat (2) @(negedge clk);
        rst_n = 1;
        acc_cnt = 0; fetch_cnt = 0; stop_at = n;
        exp_q.delete(); acc_ops.delete(); acc_cyc.delete();
        model_run(start, n);
        @(negedge clk);
        pc_load = 1; pc_load_val = 8'(start); en = 1; c0 = cyc;
        @(negedge clk);
        pc_load = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #3;
            done = acc_cnt == n && !busy;
        end
        if (!done) check("run_timeout", acc_cnt, n);
        check("end_pc", pc, m_pc);
        check("end_sp", sp, m_sp);
        check("end_ovf", stack_ovf, m_ovf);
        check("end_unf", stack_unf, m_unf);
        check("fetch_count", fetch_cnt, m_fetch);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) rr_seq[i] = 1'b0;
    endtask

    initial begin
        rst_n = 0; en = 0; pc_load = 0; pc_load_val = 0;
        mem_ack = 0; mem_rdata = 0; core_ready = 0; core_rr = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        #3;
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue", {issue_op, issue_opr}, 0);
        check("rst_pc", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_flags", {stack_ovf, stack_unf}, 0);

        mem[0] = 8'h11; mem[1] = 8'h83; mem[2] = 8'h00;
        run(0, 3, 100, 100);
        check("lat_n", acc_cyc.size(), 3);
        for (int i = 0; i < 3 && i < acc_cyc.size(); i++) check("lat_cycle", acc_cyc[i] - c0, 2 * i + 2);
        check("lat_pc", pc, 3);

        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'h10; mem[2] = 8'h22; mem[3] = 8'h33; mem[8'h10] = 8'hD0;
        run(0, 3, 100, 100);
        check("call_ops", {acc_ops[0], acc_ops[1], acc_ops[2]}, 24'hC0D033);
        check("call_sp", sp, 0);

        clear_mem();
        mem[0] = 8'hE0; mem[1] = 8'hC0; mem[2] = 8'h20; mem[3] = 8'h15;
        run(0, 2, 100, 100);
        check("skz0_ops", {acc_ops[0], acc_ops[1]}, 16'hE015);
        check("skz0_pc", pc, 4);
        rr_seq[0] = 1'b1;
        run(0, 2, 100, 100);
        check("skz1_ops", {acc_ops[0], acc_ops[1]}, 16'hE0C0);
        check("skz1_pc", pc, 8'h20);

        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'h10; mem[8'h10] = 8'hC1; mem[8'h11] = 8'h20;
        mem[8'h20] = 8'hC2; mem[8'h21] = 8'h30;
        run(0, 3, 100, 100);
        check("ovf_sp", sp, 2);
        check("ovf_flag", stack_ovf, 1);
        check("ovf_pc", pc, 8'h30);
        clear_mem();
        mem[0] = 8'hD0; mem[1] = 8'h11; mem[2] = 8'h12;
        run(0, 2, 100, 100);
        check("unf_ops", {acc_ops[0], acc_ops[1]}, 16'hD012);
        check("unf_flag", stack_unf, 1);

        clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run(8'h37, 20, 25, 35);
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                rr_seq[i] = 1'($urandom);
            end
            run($urandom_range(255), 25 + s * 5, s % 2 ? 100 : $urandom_range(20, 90), s % 2 ? 100 : $urandom_range(20, 90));
        end

        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'h08; mem[8] = 8'h35;
        run(0, 2, 60, 40);
        check("drop_busy", busy, 0);
        check("drop_sp_kept", sp, 1);
        ack_pct = 0;
        @(negedge clk);
        pc_load = 1; pc_load_val = 8'h40;
        @(negedge clk);
        pc_load = 0;
        #3;
        check("load_pc", pc, 8'h40);
        check("load_sp", sp, 0);
        check("load_busy", busy, 0);
        @(negedge clk);
        en = 1;
        repeat (2) @(negedge clk);
        #3;
        check("restart_req", mem_req, 1);
        check("restart_addr", mem_addr, 8'h40);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        #3;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_pc", pc, 0);
        check("rst_mid_busy", busy, 0);
        rst_n = 1; en = 0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
